traffic_sequencer: RTL

//  Timed state machine driving the Lights decoder: produces the 7-bit light_signals word
//  {Rm,Ym,Gm,Rs,Ys,Gs,W}. Main road rests on green; side-road sensor and pedestrian

---
 rtl/traffic_sequencer.sv | 137 +++++++++++++
 1 files changed

// File: rtl/traffic_sequencer.sv
// rtl/traffic_sequencer.sv - timed main/side/walk traffic light sequencer
//
// Purpose: main road rests on green. Side-road and pedestrian requests are
// latched and served after a minimum main-green time, with yellow and all-red
// clearance phases. All durations are counted in i_tick pulses.
//
// Ports:
//   i_clk            rising-edge clock
//   i_rst_n          asynchronous reset, active low
//   i_tick           one-clock-wide timing enable
//   i_side_sensor    side-road vehicle present (level, sampled every clock)
//   i_walk_req       pedestrian button (sampled every clock)
//   o_light_signals  {Rm,Ym,Gm,Rs,Ys,Gs,W}, registered
//   o_side_pending   latched side request
//   o_walk_pending   latched walk request
//   o_phase          current state encoding (debug)

module traffic_sequencer #(
  parameter int CNT_W        = 8,
  parameter int T_MG_MIN     = 20,
  parameter int T_YELLOW     = 3,
  parameter int T_ALL_RED    = 2,
  parameter int T_SIDE_GREEN = 10,
  parameter int T_WALK       = 8
) (
  input  logic       i_clk,
  input  logic       i_rst_n,
  input  logic       i_tick,
  input  logic       i_side_sensor,
  input  logic       i_walk_req,
  output logic [6:0] o_light_signals,
  output logic       o_side_pending,
  output logic       o_walk_pending,
  output logic [2:0] o_phase
);

  typedef enum logic [2:0] {
    S_MG   = 3'd0,
    S_MY   = 3'd1,
    S_AR_A = 3'd2,
    S_SG   = 3'd3,
    S_SY   = 3'd4,
    S_AR_B = 3'd5,
    S_WALK = 3'd6,
    S_BAD  = 3'd7
  } state_t;

  // Last count value of each phase; a tick seen at this value ends the phase.
  localparam logic [CNT_W-1:0] L_MG   = CNT_W'(T_MG_MIN - 1);
  localparam logic [CNT_W-1:0] L_YEL  = CNT_W'(T_YELLOW - 1);
  localparam logic [CNT_W-1:0] L_AR   = CNT_W'(T_ALL_RED - 1);
  localparam logic [CNT_W-1:0] L_SG   = CNT_W'(T_SIDE_GREEN - 1);
  localparam logic [CNT_W-1:0] L_WALK = CNT_W'(T_WALK - 1);

  state_t           r_state;
  state_t           w_next;
  logic [CNT_W-1:0] r_cnt;
  logic [6:0]       r_lights;
  logic             r_side_pending;
  logic             r_walk_pending;
  logic             w_enter_sg;
  logic             w_enter_walk;
  logic             w_cnt_hold;

  function automatic logic [6:0] lights_of(input state_t s);
    case (s)
      S_MG:    lights_of = 7'b0011000;
      S_MY:    lights_of = 7'b0101000;
      S_AR_A:  lights_of = 7'b1001000;
      S_SG:    lights_of = 7'b1000010;
      S_SY:    lights_of = 7'b1000100;
      S_WALK:  lights_of = 7'b1001001;
      default: lights_of = 7'b1001000;
    endcase
  endfunction

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_MG:
        if (i_tick && (r_cnt == L_MG) && (r_side_pending || r_walk_pending))
          w_next = S_MY;
      S_MY:
        if (i_tick && (r_cnt == L_YEL)) w_next = S_AR_A;
      S_AR_A:
        if (i_tick && (r_cnt == L_AR)) begin
          if (r_side_pending)      w_next = S_SG;
          else if (r_walk_pending) w_next = S_WALK;
          else                     w_next = S_MG;
        end
      S_SG:
        if (i_tick && (r_cnt == L_SG)) w_next = S_SY;
      S_SY:
        if (i_tick && (r_cnt == L_YEL)) w_next = S_AR_B;
      S_AR_B:
        if (i_tick && (r_cnt == L_AR)) begin
          if (r_walk_pending) w_next = S_WALK;
          else                w_next = S_MG;
        end
      S_WALK:
        if (i_tick && (r_cnt == L_WALK)) w_next = S_AR_B;
      default:
        w_next = S_AR_B;
    endcase
  end

  assign w_enter_sg   = (w_next == S_SG)   && (r_state != S_SG);
  assign w_enter_walk = (w_next == S_WALK) && (r_state != S_WALK);
  // Main green parks its counter at the minimum so a late request exits on the next tick.
  assign w_cnt_hold   = (r_state == S_MG) && (r_cnt == L_MG);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state        <= S_AR_B;
      r_cnt          <= '0;
      r_lights       <= 7'b1001000;
      r_side_pending <= 1'b0;
      r_walk_pending <= 1'b0;
    end else begin
      r_state  <= w_next;
      r_lights <= lights_of(w_next);
      if (w_next != r_state)
        r_cnt <= '0;
      else if (i_tick && !w_cnt_hold)
        r_cnt <= r_cnt + CNT_W'(1);
      // A request arriving on the serving clock survives for the next round.
      r_side_pending <= (r_side_pending && !w_enter_sg)   || i_side_sensor;
      r_walk_pending <= (r_walk_pending && !w_enter_walk) || i_walk_req;
    end
  end

  assign o_light_signals = r_lights;
  assign o_side_pending  = r_side_pending;
  assign o_walk_pending  = r_walk_pending;
  assign o_phase         = r_state;

endmodule
